c499_sec_encoder: RTL and testbench

C499_SEC_ENCODER -- requirements
Module: c499_sec_encoder

---
 rtl/c499_sec_encoder_if.sv | 29 ++
 rtl/c499_sec_encoder.sv | 186 ++++++++++++++++++
 tb/tb_c499_sec_encoder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/c499_sec_encoder_if.sv
// c499_sec_encoder_if
// Stream and error-injection signals of the C499 SEC encoder.
//   in_valid/in_ready/in_data          : input data-word handshake
//   out_valid/out_ready/out_data/out_check : codeword handshake
//   inj_arm/inj_idx/inj_pending        : error-injection control and status
// The master modport is the environment (producer and consumer side).
// The slave modport is the encoder.
interface c499_sec_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        inj_arm;
  logic [5:0]  inj_idx;
  logic        inj_pending;

  modport master (
    output in_valid, in_data, out_ready, inj_arm, inj_idx,
    input  in_ready, out_valid, out_data, out_check, inj_pending
  );

  modport slave (
    input  in_valid, in_data, out_ready, inj_arm, inj_idx,
    output in_ready, out_valid, out_data, out_check, inj_pending
  );
endinterface

// File: rtl/c499_sec_encoder.sv
// c499_sec_encoder
// Two-stage encoder that produces the eight check bits of the C499
// single-error-correcting code for a 32-bit data word. It can flip one
// chosen codeword bit on a later word, so the corrector can be exercised.
// Ports:
//   clk      : clock; all state updates on the rising edge
//   rst      : synchronous active-high reset
//   bus      : stream and injection signals (slave modport)
//   word_cnt : saturating count of delivered codewords
//   inj_cnt  : saturating count of delivered codewords carrying a flip
module c499_sec_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  c499_sec_encoder_if.slave bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] inj_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // XOR of each 4-bit nibble; bit k covers data[4k+3:4k].
  function automatic logic [7:0] nib_par(input logic [31:0] d);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) begin
      p[k] = ^d[4*k +: 4];
    end
    return p;
  endfunction

  // Column parities: bit j (0..3) = d[j]^d[j+4]^d[j+8]^d[j+12],
  // bit 4+j = the same column taken over the upper half-word.
  function automatic logic [7:0] col_par(input logic [31:0] d);
    logic [7:0] p;
    for (int j = 0; j < 4; j++) begin
      p[j]   = d[j]      ^ d[j + 4]  ^ d[j + 8]  ^ d[j + 12];
      p[j+4] = d[j + 16] ^ d[j + 20] ^ d[j + 24] ^ d[j + 28];
    end
    return p;
  endfunction

  // Combine column parities with nibble parities of the opposite half-word.
  function automatic logic [7:0] check_bits(input logic [7:0] np, input logic [7:0] cp);
    logic [7:0] c;
    c[0] = cp[0] ^ np[4] ^ np[5];
    c[1] = cp[1] ^ np[6] ^ np[7];
    c[2] = cp[2] ^ np[4] ^ np[6];
    c[3] = cp[3] ^ np[5] ^ np[7];
    c[4] = cp[4] ^ np[0] ^ np[1];
    c[5] = cp[5] ^ np[2] ^ np[3];
    c[6] = cp[6] ^ np[0] ^ np[2];
    c[7] = cp[7] ^ np[1] ^ np[3];
    return c;
  endfunction

  logic        advance_s;
  logic        accept_s;
  logic        deliver_s;
  logic        arm_ok_s;
  logic        inj_flag_s;
  logic [5:0]  inj_sel_s;
  logic [7:0]  chk_s;
  logic [39:0] flip_s;

  logic        pend_r;
  logic [5:0]  pend_idx_r;

  logic        s1_valid_r;
  logic [31:0] s1_data_r;
  logic [7:0]  s1_nib_r;
  logic [7:0]  s1_col_r;
  logic        s1_flag_r;
  logic [5:0]  s1_idx_r;

  logic        s2_valid_r;
  logic [31:0] s2_data_r;
  logic [7:0]  s2_check_r;
  logic        s2_flag_r;

  logic [CNT_W-1:0] word_cnt_r;
  logic [CNT_W-1:0] inj_cnt_r;

  // Global stall: the whole pipeline moves only when the output slot frees.
  always_comb begin
    advance_s = !s2_valid_r | bus.out_ready;
    accept_s  = advance_s & bus.in_valid;
    deliver_s = s2_valid_r & bus.out_ready;
    arm_ok_s  = bus.inj_arm & (bus.inj_idx <= 6'd39);
  end

  // A valid arm in the acceptance cycle overrides any older pending index.
  always_comb begin
    inj_flag_s = pend_r;
    inj_sel_s  = pend_idx_r;
    if (arm_ok_s) begin
      inj_flag_s = 1'b1;
      inj_sel_s  = bus.inj_idx;
    end else begin
      inj_flag_s = pend_r;
      inj_sel_s  = pend_idx_r;
    end
  end

  // Final check bits and the one-hot flip mask over {check, data}.
  always_comb begin
    chk_s  = check_bits(s1_nib_r, s1_col_r);
    flip_s = 40'd0;
    if (s1_flag_r) begin
      flip_s = 40'd1 << s1_idx_r;
    end else begin
      flip_s = 40'd0;
    end
  end

  // Pending-injection latch; consumed by the next accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= 1'b0;
      pend_idx_r <= 6'd0;
    end else if (accept_s) begin
      pend_r     <= 1'b0;
    end else if (arm_ok_s) begin
      pend_r     <= 1'b1;
      pend_idx_r <= bus.inj_idx;
    end
  end

  // Stage 1: register data with its nibble and column parities.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 32'd0;
      s1_nib_r   <= 8'd0;
      s1_col_r   <= 8'd0;
      s1_flag_r  <= 1'b0;
      s1_idx_r   <= 6'd0;
    end else if (advance_s) begin
      s1_valid_r <= bus.in_valid;
      s1_data_r  <= bus.in_data;
      s1_nib_r   <= nib_par(bus.in_data);
      s1_col_r   <= col_par(bus.in_data);
      s1_flag_r  <= bus.in_valid & inj_flag_s;
      s1_idx_r   <= inj_sel_s;
    end
  end

  // Stage 2: final codeword with any requested flip applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= 32'd0;
      s2_check_r <= 8'd0;
      s2_flag_r  <= 1'b0;
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s1_data_r ^ flip_s[31:0];
      s2_check_r <= chk_s ^ flip_s[39:32];
      s2_flag_r  <= s1_valid_r & s1_flag_r;
    end
  end

  // Saturating delivery statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= '0;
      inj_cnt_r  <= '0;
    end else if (deliver_s) begin
      if (word_cnt_r != CNT_MAX) begin
        word_cnt_r <= word_cnt_r + 1'b1;
      end
      if (s2_flag_r && (inj_cnt_r != CNT_MAX)) begin
        inj_cnt_r <= inj_cnt_r + 1'b1;
      end
    end
  end

  assign bus.in_ready    = advance_s;
  assign bus.out_valid   = s2_valid_r;
  assign bus.out_data    = s2_data_r;
  assign bus.out_check   = s2_check_r;
  assign bus.inj_pending = pend_r;
  assign word_cnt        = word_cnt_r;
  assign inj_cnt         = inj_cnt_r;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Testbench for c499_sec_encoder: directed table, injection and reset
// sequences, and a random stream against a mask-based reference model.
module tb_c499_sec_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] word_cnt;
  logic [15:0] inj_cnt;

  c499_sec_encoder_if bus ();

  c499_sec_encoder #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .word_cnt (word_cnt),
    .inj_cnt  (inj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [39:0] cw;
    logic        flag;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
  } vec_t;

  exp_t        q[$];
  int          n_vec;
  int          n_bad;
  logic        m_pend;
  logic [5:0]  m_pidx;
  int          m_wcnt;
  int          m_icnt;
  logic        hold_active;
  logic [39:0] held_cw;
  logic        s_valid;
  logic [31:0] s_data;
  logic [7:0]  s_check;
  logic        last_acc;

  // Check bit i is the parity of data under mask i, straight from the code definition.
  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [31:0] m [8];
    logic [7:0]  c;
    m[0] = 32'h00FF1111; m[1] = 32'hFF002222;
    m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
    m[4] = 32'h111100FF; m[5] = 32'h2222FF00;
    m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
    for (int i = 0; i < 8; i++) c[i] = ^(d & m[i]);
    return c;
  endfunction

  // Behavioural corrector: flip the data bit whose column equals the syndrome.
  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] r;
    logic [31:0] one;
    syn = ref_check(d) ^ c;
    r   = d;
    for (int i = 0; i < 32; i++) begin
      one = 32'd1 << i;
      if (syn != 8'd0 && syn == ref_check(one)) r = d ^ one;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, book handshakes for the coming edge.
  task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                      input logic arm, input logic [5:0] idx);
    exp_t        e;
    logic        arm_ok;
    logic        flag;
    logic [5:0]  sel;
    logic [39:0] one40;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.inj_arm   = arm;
    bus.inj_idx   = idx;
    #1;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_check = bus.out_check;
    cmp("inj_pending", {63'd0, bus.inj_pending}, {63'd0, m_pend});
    cmp("word_cnt", {48'd0, word_cnt}, 64'(m_wcnt));
    cmp("inj_cnt", {48'd0, inj_cnt}, 64'(m_icnt));
    if (hold_active) begin
      cmp("stall_valid", {63'd0, s_valid}, 64'd1);
      cmp("stall_cw", {24'd0, s_check, s_data}, {24'd0, held_cw});
    end
    if (s_valid && ordy) begin
      if (q.size() == 0) begin
        cmp("unexpected_delivery", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        cmp("codeword", {24'd0, s_check, s_data}, {24'd0, e.cw});
        cmp("corrected", {32'd0, correct(s_data, s_check)}, {32'd0, e.data});
        if (m_wcnt < 65535) m_wcnt++;
        if (e.flag && m_icnt < 65535) m_icnt++;
      end
    end
    hold_active = s_valid && !ordy;
    held_cw     = {s_check, s_data};
    arm_ok   = arm && (idx < 6'd40);
    last_acc = v && bus.in_ready;
    if (last_acc) begin
      flag   = arm_ok || m_pend;
      sel    = arm_ok ? idx : m_pidx;
      one40  = 40'd1 << sel;
      e.data = d;
      e.flag = flag;
      e.cw   = {ref_check(d), d} ^ (flag ? one40 : 40'd0);
      q.push_back(e);
      m_pend = 1'b0;
    end else if (arm_ok) begin
      m_pend = 1'b1;
      m_pidx = idx;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inj_arm   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_pend = 1'b0;
    m_wcnt = 0;
    m_icnt = 0;
    hold_active = 1'b0;
    #1;
    cmp("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    cmp("rst_inj_pending", {63'd0, bus.inj_pending}, 64'd0);
    cmp("rst_word_cnt", {48'd0, word_cnt}, 64'd0);
    cmp("rst_inj_cnt", {48'd0, inj_cnt}, 64'd0);
    cmp("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    cmp("rst_out_check", {56'd0, bus.out_check}, 64'd0);
    cmp("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // Send one word, two bubbles; the third step samples the word right after edge N+2.
  task automatic send_and_look(input logic [31:0] d, input logic arm, input logic [5:0] idx);
    step(1'b1, d, 1'b1, arm, idx);
    step(1'b0, 32'd0, 1'b1, 1'b0, 6'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 6'd0);
    cmp("latency_valid", {63'd0, s_valid}, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) step(1'b0, 32'd0, 1'b1, 1'b0, 6'd0);
    cmp("drain_empty", 64'(q.size()), 64'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 6'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   sent;
    int   cyc;
    logic v;
    logic ordy;
    n_vec = 0; n_bad = 0;
    m_pend = 1'b0; m_pidx = 6'd0; m_wcnt = 0; m_icnt = 0;
    hold_active = 1'b0; held_cw = 40'd0; last_acc = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b1;
    bus.inj_arm = 1'b0; bus.inj_idx = 6'd0;
    repeat (2) @(posedge clk);
    do_reset();

    tbl[0] = '{32'h00000000, 8'h00};
    tbl[1] = '{32'h00000001, 8'h51};
    tbl[2] = '{32'h00010000, 8'h15};
    tbl[3] = '{32'hFFFFFFFF, 8'h00};
    tbl[4] = '{32'h80000000, 8'h8A};
    tbl[5] = '{32'h00000020, 8'h92};
    for (int i = 0; i < 6; i++) begin
      send_and_look(tbl[i].data, 1'b0, 6'd0);
      cmp("table_data", {32'd0, s_data}, {32'd0, tbl[i].data});
      cmp("table_check", {56'd0, s_check}, {56'd0, tbl[i].chk});
    end
    drain();

    // Random stream with a 5-cycle output stall in the middle.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 100 && cyc < 2000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = !(cyc >= 40 && cyc < 45);
      step(v, $urandom, ordy, 1'b0, 6'd0);
      if (last_acc) sent++;
      cyc++;
    end
    drain();
    cmp("stream_word_cnt", {48'd0, word_cnt}, 64'd100);

    // Injection on data bit 5.
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd5);
    send_and_look(32'd0, 1'b0, 6'd0);
    cmp("inj5_data", {32'd0, s_data}, 64'h20);
    cmp("inj5_check", {56'd0, s_check}, 64'h00);
    drain();
    cmp("inj5_cnt", {48'd0, inj_cnt}, 64'd1);

    // Injection on check bit 1.
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd33);
    send_and_look(32'd0, 1'b0, 6'd0);
    cmp("inj33_check", {56'd0, s_check}, 64'h02);

    // Out-of-range index is ignored.
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd45);
    step(1'b0, 32'd0, 1'b1, 1'b0, 6'd0);
    send_and_look(32'd1, 1'b0, 6'd0);
    cmp("inj45_data", {32'd0, s_data}, 64'h1);
    cmp("inj45_check", {56'd0, s_check}, 64'h51);

    // Arm coinciding with acceptance applies to that word.
    send_and_look(32'd1, 1'b1, 6'd7);
    cmp("inj_same_edge", {32'd0, s_data}, 64'h81);

    // Re-arm keeps the latest index.
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd2);
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd9);
    send_and_look(32'd0, 1'b0, 6'd0);
    cmp("inj_rearm", {32'd0, s_data}, 64'h200);
    drain();

    // Reset with words in flight and an injection armed.
    step(1'b1, 32'h12345678, 1'b1, 1'b0, 6'd0);
    step(1'b1, 32'h9ABCDEF0, 1'b1, 1'b0, 6'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 6'd3);
    do_reset();
    send_and_look(32'h00010000, 1'b0, 6'd0);
    cmp("post_rst_check", {56'd0, s_check}, 64'h15);
    cmp("post_rst_data", {32'd0, s_data}, 64'h00010000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
